pool_win_addr_gen: RTL
======================

POOL_WIN_ADDR_GEN -- requirements
Module: pool_win_addr_gen

Interface
REQ-001 Parameter IMG_W, default 24: feature-map width in pixels.
REQ-002 Parameter IMG_H, default 24: feature-map height in pixels.
REQ-003 Parameter WIN, default 2: square pooling window side; stride equals WIN.
REQ-004 Parameter CHANNELS, default 1: number of feature maps, stored back-to-back.
REQ-005 Parameter ADDR_W, default 10: address width; must hold CHANNELS*IMG_W*IMG_H-1 (plus base when enabled).
REQ-006 Parameter GAP, default 0: idle cycles inserted after each accepted window.
REQ-007 clk  in  1  clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 start  in  1  one-cycle request to begin a full scan; honoured only in IDLE.
REQ-010 addr  out  WIN*WIN x ADDR_W  window addresses; element k = row i*WIN + column j.
REQ-011 addr_valid  out  1  addr holds a valid window.
REQ-012 addr_ready  in  1  consumer accepts window when high with addr_valid.
REQ-013 last  out  1  high with addr_valid on the final window of the scan.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse after final window accepted.

Function
REQ-016 States: IDLE, ISSUE, GAP_WAIT, DONE; IDLE->ISSUE on start.
REQ-017 addr[i*WIN+j] = base + ch*IMG_W*IMG_H + (wy*WIN+i)*IMG_W + wx*WIN + j, modulo 2^ADDR_W.
REQ-018 Scan order: wx fastest (0..IMG_W/WIN-1), then wy, then ch.
REQ-019 First window presented the cycle after start is sampled (latency 1).
REQ-020 In ISSUE, addr_valid high; addr and last held stable until addr_valid && addr_ready.
REQ-021 On transfer: GAP>0 -> GAP_WAIT for exactly GAP cycles with addr_valid low, then ISSUE; GAP=0 -> next window presented the following cycle, no bubble.
REQ-022 Transfer of window with last=1 -> DONE; done high for that one cycle; then IDLE.
REQ-023 start while busy is ignored; start in the DONE cycle is ignored.
REQ-024 Window counters wrap: wx wraps to 0 incrementing wy; wy wraps to 0 incrementing ch.
REQ-025 IMG_W or IMG_H not a multiple of WIN shall fail elaboration; trailing pixels never addressed.

Reset
REQ-026 On reset: state IDLE, addr all 0, addr_valid 0, last 0, busy 0, done 0, counters 0.
REQ-027 Reset mid-scan aborts immediately; no done pulse; next start restarts at window 0.

Configuration
REQ-028 Macro POOL_RD_BASE_EN defined: input base_addr (ADDR_W) latched on accepted start and added per REQ-017.
REQ-029 Macro undefined: no base_addr port; base is constant 0.

Structure
REQ-030 Package pool_pkg holds the state enum and a function computing minimum ADDR_W from IMG_W, IMG_H, CHANNELS.
REQ-031 Nested wx/wy/ch counter with wrap and last-window flag is sub-module win_cnt.

Verification
REQ-032 Defaults, ready=1, start -> window 0 addr {0,1,24,25}; window 11 {22,23,46,47}; window 12 {48,49,72,73}.
REQ-033 Defaults -> window 143 {550,551,574,575} with last=1; done pulses next cycle; exactly 144 transfers.
REQ-034 addr_ready low 3 cycles on window 5 -> addr {10,11,34,35} and addr_valid held stable 4 cycles.
REQ-035 GAP=2, ready=1 -> addr_valid high 1 cycle in every 3.
REQ-036 CHANNELS=2, ADDR_W=11 -> window 144 {576,577,600,601}; last only on window 287.
REQ-037 POOL_RD_BASE_EN, base_addr=1000, ADDR_W=11 -> window 0 {1000,1001,1024,1025}; reset asserted at window 50 -> all outputs 0, no done.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared state encoding and sizing helpers for the pooling window address generator.
package pool_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP_WAIT, DONE} state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int min_addr_w(input int img_w, input int img_h, input int channels);
      return cnt_w(img_w * img_h * channels);
   endfunction

endpackage

// File: rtl/pool_win_addr_gen_win_cnt.sv
// win_cnt: nested window counter, wx fastest then wy then ch, flagging the final window of a scan.
module win_cnt
   import pool_pkg::*;
#(
   parameter int NX = 12,
   parameter int NY = 12,
   parameter int NC = 1,
   parameter int XW = cnt_w(NX),
   parameter int YW = cnt_w(NY),
   parameter int CW = cnt_w(NC)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [XW-1:0] wx,
   output logic [YW-1:0] wy,
   output logic [CW-1:0] ch,
   output logic          last
);
   localparam logic [XW-1:0] XL = XW'(NX - 1);
   localparam logic [YW-1:0] YL = YW'(NY - 1);
   localparam logic [CW-1:0] CL = CW'(NC - 1);

   assign last = (wx == XL) && (wy == YL) && (ch == CL);

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wx <= '0;
         wy <= '0;
         ch <= '0;
      end else if (clr) begin
         wx <= '0;
         wy <= '0;
         ch <= '0;
      end else if (inc) begin
         wx <= (wx == XL) ? '0 : wx + 1'b1;
         if (wx == XL) begin
            wy <= (wy == YL) ? '0 : wy + 1'b1;
            if (wy == YL) ch <= (ch == CL) ? '0 : ch + 1'b1;
         end
      end

endmodule

// File: rtl/pool_win_addr_gen.sv
// pool_win_addr_gen: scans all WINxWIN pooling windows (stride WIN) and presents their pixel addresses.
// Define POOL_RD_BASE_EN to add a base_addr input latched on an accepted start.
module pool_win_addr_gen
   import pool_pkg::*;
#(
   parameter int IMG_W    = 24,
   parameter int IMG_H    = 24,
   parameter int WIN      = 2,
   parameter int CHANNELS = 1,
   parameter int ADDR_W   = 10,
   parameter int GAP      = 0
) (
   input  logic                             clk,
   input  logic                             reset,
`ifdef POOL_RD_BASE_EN
   input  logic [ADDR_W-1:0]                base_addr,
`endif
   input  logic                             start,
   output logic [WIN*WIN-1:0][ADDR_W-1:0]   addr,
   output logic                             addr_valid,
   input  logic                             addr_ready,
   output logic                             last,
   output logic                             busy,
   output logic                             done
);
   localparam int NX = IMG_W / WIN;
   localparam int NY = IMG_H / WIN;
   localparam int GW = cnt_w(GAP + 1);

   if ((IMG_W % WIN) != 0 || (IMG_H % WIN) != 0) begin : g_bad_dim
      $error("pool_win_addr_gen: IMG_W and IMG_H must be multiples of WIN");
   end
   if (ADDR_W < min_addr_w(IMG_W, IMG_H, CHANNELS)) begin : g_bad_aw
      $error("pool_win_addr_gen: ADDR_W too narrow for the feature maps");
   end

   state_t                  state, state_nx;
   logic [GW-1:0]           gap_cnt, gap_nx;
   logic [ADDR_W-1:0]       base;
   logic [cnt_w(NX)-1:0]    wx;
   logic [cnt_w(NY)-1:0]    wy;
   logic [cnt_w(CHANNELS)-1:0] ch;
   logic                    win_last, go, xfer;
   logic [31:0]             origin;

   assign go         = (state == IDLE) && start;
   assign addr_valid = (state == ISSUE);
   assign xfer       = addr_valid && addr_ready;
   assign last       = addr_valid && win_last;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

`ifdef POOL_RD_BASE_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) base <= '0;
      else if (go) base <= base_addr;
`else
   assign base = '0;
`endif

   win_cnt #(.NX(NX), .NY(NY), .NC(CHANNELS)) u_cnt (
      .clk(clk), .reset(reset), .clr(go), .inc(xfer),
      .wx(wx), .wy(wy), .ch(ch), .last(win_last)
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= IDLE;
         gap_cnt <= '0;
      end else begin
         state   <= state_nx;
         gap_cnt <= gap_nx;
      end

   always_comb begin
      state_nx = state;
      gap_nx   = gap_cnt;
      case (state)
         IDLE:     if (start) state_nx = ISSUE;
         ISSUE:    if (xfer) begin
                      state_nx = win_last ? DONE : (GAP > 0) ? GAP_WAIT : ISSUE;
                      gap_nx   = GW'((GAP > 0) ? GAP - 1 : 0);
                   end
         GAP_WAIT: begin
                      gap_nx = gap_cnt - 1'b1;
                      if (gap_cnt == '0) state_nx = ISSUE;
                   end
         default:  state_nx = IDLE;
      endcase
   end

   // Top-left pixel of the window; each element then offsets by row and column, wrapping at 2^ADDR_W.
   always_comb begin
      addr   = '0;
      origin = 32'(base) + 32'(ch) * 32'(IMG_W * IMG_H) + 32'(wy) * 32'(WIN * IMG_W) + 32'(wx) * 32'(WIN);
      if (addr_valid)
         for (int k = 0; k < WIN * WIN; k++)
            addr[k] = ADDR_W'(origin + 32'((k / WIN) * IMG_W + (k % WIN)));
   end

endmodule
